alu_bitserial_seq: RTL and testbench
====================================

Name: alu_bitserial_seq

Overview:
Bit-serial ALU sequencer that sits directly upstream of the 1-bit 4:1 select stage. It latches two WIDTH-bit operands and a 2-bit opcode, then processes one bit per clock, LSB first. Each cycle it forms the four candidate bits (AND, OR, XOR, SUM), uses the opcode as the 4:1 select, and assembles the result with a carry chain. Result, carry and zero flags are presented with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when the block is idle or in DONE
op  in  2  00 AND, 01 OR, 10 XOR, 11 ADD (select order of the 4:1 stage)
a  in  WIDTH  operand A, sampled with start
b  in  WIDTH  operand B, sampled with start
busy  out  1  high while bits are being processed
done  out  1  one-cycle pulse when result/flags update
result  out  WIDTH  last completed result, held until the next completion
carry_out  out  1  final carry for ADD; 0 for logic ops
zero  out  1  high when result == 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, carry_out=0, zero=1; internal shift registers, bit counter and carry are cleared. Asserting reset mid-RUN aborts the operation, and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch a, b and op into shift registers; carry=0; count=0; go to RUN. With start=0, DONE goes to IDLE.
- RUN, per cycle:
  - s=a_sh[0]^b_sh[0]^carry.
  - Candidates: {a&b, a|b, a^b, s}. The selected bit, chosen by op, shifts into the result shadow register at the MSB, and the shadow shifts right.
  - a_sh and b_sh shift right.
  - For op=ADD, carry <= majority(a_sh[0], b_sh[0], carry). For other ops carry holds 0.
  - count increments. When count==WIDTH-1, go to DONE.
- Entering DONE: result <= final shadow value (including the last bit), carry_out <= carry (0 for logic ops), zero <= (new result==0), done=1 for exactly that cycle.
- Latency: start sampled at edge N gives busy=1 from N to N+WIDTH-1 and done=1 in the cycle after edge N+WIDTH. The next start can be accepted in the DONE cycle (back-to-back).
- start while busy is ignored, with no effect on operands or op.
- The result, carry_out and zero outputs do not change during RUN. They update only on entry to DONE.
- Inputs a, b and op may change freely after the accepting edge.
- Width rules: all arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide and has no wrap beyond WIDTH-1.

Optional Feature:
- Macro: ALU_SUB_EN.
- Defined:
  - Adds input port sub (1 bit). It is sampled with start and used only when op=ADD.
  - With sub=1, the b bits are inverted as they are consumed and the carry is initialised to 1, giving the two's-complement result a-b.
  - carry_out=1 means no borrow (a>=b, unsigned).
- Undefined: the sub port is absent and op=ADD performs addition only.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11.
  - State encoding ST_IDLE, ST_RUN, ST_DONE.
- Sub-module alu_bit_slice (combinational):
  - Inputs: a_bit, b_bit, cin, op.
  - Outputs: the selected bit and cout.
  - It produces the four candidates and selects with op. The sequencer instantiates it once and owns all state.

Test Plan:
1. WIDTH=8, op=ADD, a=0x5A, b=0x3C, start one cycle -> busy for 8 cycles; done after 9 edges; result=0x96, carry_out=0, zero=0.
2. op=ADD, a=0xFF, b=0x01 -> result=0x00, carry_out=1, zero=1.
3. a=0xF0, b=0x3C, back-to-back starts issued in each DONE cycle:
   - AND -> 0x30
   - OR -> 0xFC
   - XOR -> 0xCC
   - carry_out=0 each time, with no idle cycle between operations.
4. ADD 0x11+0x22 started, then start pulsed at cycle 3 with a=0xAA, b=0x55 -> the second start is ignored; result=0x33 and only one done pulse.
5. ADD started, rst_n pulled low mid-RUN at cycle 4 -> busy=0, result=0, zero=1 immediately and no done. After release, a new AND 0x0F&0xFF gives 0x0F.
6. ALU_SUB_EN defined, op=ADD, sub=1:
   - 0x10-0x01 -> 0x0F, carry_out=1.
   - 0x01-0x02 -> 0xFF, carry_out=0.

Source files
------------

// File: rtl/alu_bitserial_seq_pkg.sv
// alu_pkg: opcodes, sequencer state encoding and the carry majority helper
// shared by the bit-serial ALU files.
`default_nettype none

package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bitserial_seq_if.sv
// alu_bitserial_seq_if: start/busy/done request bus of the bit-serial ALU.
// Optional macro ALU_SUB_EN adds the sub request bit.
`default_nettype none

interface alu_bitserial_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ALU_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

`ifdef ALU_SUB_EN
    modport master (output start, op, a, b, sub,
                    input  busy, done, result, carry_out, zero);
    modport slave  (input  start, op, a, b, sub,
                    output busy, done, result, carry_out, zero);
`else
    modport master (output start, op, a, b,
                    input  busy, done, result, carry_out, zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, carry_out, zero);
`endif
endinterface

`default_nettype wire

// File: rtl/alu_bitserial_seq_bit_slice.sv
// alu_bit_slice: one-bit ALU cell, forms AND/OR/XOR/SUM and selects by op.
`default_nettype none

module alu_bit_slice
    import alu_pkg::*;
(
    input  wire logic       a_bit,
    input  wire logic       b_bit,
    input  wire logic       cin,
    input  wire logic [1:0] op,
    output logic            y,
    output logic            cout
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = a_bit & b_bit;
            OP_OR:   y = a_bit | b_bit;
            OP_XOR:  y = a_bit ^ b_bit;
            default: y = a_bit ^ b_bit ^ cin;
        endcase
        // Logic ops never propagate a carry, so the chain stays at zero.
        cout = (op == OP_ADD) ? maj3(a_bit, b_bit, cin) : 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq: LSB-first bit-serial ALU sequencer (IDLE/RUN/DONE).
// Optional macro ALU_SUB_EN enables a-b via inverted b and carry-in of 1.
`default_nettype none

module alu_bitserial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_bitserial_seq_if.slave bus
);

    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, shadow, result_r;
    logic [1:0]       op_r;
    logic             carry, busy_r, done_r, carry_out_r, zero_r;
    logic [CNT_W-1:0] cnt;
    logic             b_bit, sel_bit, cout;
    logic [WIDTH-1:0] shadow_nxt;

`ifdef ALU_SUB_EN
    logic sub_r;
    assign b_bit = b_sh[0] ^ (sub_r & (op_r == OP_ADD));
`else
    assign b_bit = b_sh[0];
`endif

    alu_bit_slice u_slice (
        .a_bit (a_sh[0]),
        .b_bit (b_bit),
        .cin   (carry),
        .op    (op_r),
        .y     (sel_bit),
        .cout  (cout)
    );

    assign shadow_nxt = {sel_bit, {(WIDTH-1){1'b0}}} | (shadow >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            shadow      <= '0;
            op_r        <= OP_AND;
            carry       <= 1'b0;
            cnt         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b1;
`ifdef ALU_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        op_r   <= bus.op;
                        shadow <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
`ifdef ALU_SUB_EN
                        sub_r  <= bus.sub;
                        carry  <= bus.sub & (bus.op == OP_ADD);
`else
                        carry  <= 1'b0;
`endif
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    shadow <= shadow_nxt;
                    carry  <= cout;
                    if (cnt == LAST) begin
                        state       <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        result_r    <= shadow_nxt;
                        carry_out_r <= cout;
                        zero_r      <= (shadow_nxt == '0);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_out_r;
    assign bus.zero      = zero_r;

endmodule

`default_nettype wire

// File: tb/tb_alu_bitserial_seq.sv
// tb_alu_bitserial_seq: directed vectors for the bit-serial ALU sequencer.
`default_nettype none

module tb_alu_bitserial_seq;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_bitserial_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic sub);
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
`ifdef ALU_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub request ignored in this build");
`endif
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a  = 8'h00;
        bus.b  = 8'h00;
        bus.op = 2'b00;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Waits for done, expecting it exactly WIDTH edges after the accepting edge.
    task automatic wait_done(input int skipped, input logic [7:0] held,
                             input logic [7:0] res, input logic cy, input logic z);
        int  k;
        bit  seen = 0;
        for (k = skipped + 1; k <= 3 * WIDTH; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (k == WIDTH / 2) chk("result_held_in_run", 32'(bus.result), 32'(held));
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_latency", k, WIDTH);
        chk("busy_low_in_done", 32'(bus.busy), 32'd0);
        chk("result", 32'(bus.result), 32'(res));
        chk("carry_out", 32'(bus.carry_out), 32'(cy));
        chk("zero", 32'(bus.zero), 32'(z));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        bus.op = 2'b00;
`ifdef ALU_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_carry", 32'(bus.carry_out), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'h5A, 8'h3C, 2'b11, 1'b0);
        wait_done(0, 8'h00, 8'h96, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);

        issue(8'hFF, 8'h01, 2'b11, 1'b0);
        wait_done(0, 8'h96, 8'h00, 1'b1, 1'b1);

        // Back-to-back: each start issued in the DONE cycle.
        issue(8'hF0, 8'h3C, 2'b00, 1'b0);
        wait_done(0, 8'h00, 8'h30, 1'b0, 1'b0);
        issue(8'hF0, 8'h3C, 2'b01, 1'b0);
        chk("b2b_no_done", 32'(bus.done), 32'd0);
        wait_done(0, 8'h30, 8'hFC, 1'b0, 1'b0);
        issue(8'hF0, 8'h3C, 2'b10, 1'b0);
        wait_done(0, 8'hFC, 8'hCC, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Start while busy must be ignored.
        issue(8'h11, 8'h22, 2'b11, 1'b0);
        @(posedge clk); #1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.op = 2'b01;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(2, 8'hCC, 8'h33, 1'b0, 1'b0);
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
            if (bus.done) chk("single_done_pulse", 32'(bus.done), 32'd0);
        end
        chk("idle_after_ignored", 32'(bus.busy), 32'd0);
        chk("result_kept", 32'(bus.result), 32'h33);

        // Reset mid-RUN aborts with no done.
        issue(8'h77, 8'h11, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_zero", 32'(bus.zero), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) chk("no_done_after_abort", 32'(bus.done | bus.busy), 32'd0);
        end
        issue(8'h0F, 8'hFF, 2'b00, 1'b0);
        wait_done(0, 8'h00, 8'h0F, 1'b0, 1'b0);

`ifdef ALU_SUB_EN
        issue(8'h10, 8'h01, 2'b11, 1'b1);
        wait_done(0, 8'h0F, 8'h0F, 1'b1, 1'b0);
        issue(8'h01, 8'h02, 2'b11, 1'b1);
        wait_done(0, 8'h0F, 8'hFF, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
